// File: rtl/div_seq.sv
// Iterative restoring divider for DIV/DIVU: one quotient bit per cycle,
// result presented as {remainder, quotient} on the HI/LO path.
module div_seq #(
   parameter int unsigned DATA_W = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  signed_div_i,
   input  logic [DATA_W-1:0]     opdata1_i,
   input  logic [DATA_W-1:0]     opdata2_i,
   input  logic                  start_i,
   input  logic                  annul_i,
   output logic [2*DATA_W-1:0]   result_o,
   output logic                  ready_o
);

   localparam int unsigned CNT_W = $clog2(DATA_W + 1);

   typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_t;

   state_t              state;
   logic [CNT_W-1:0]    counter;
   logic [DATA_W-1:0]   rem;
   logic [DATA_W-1:0]   quo;
   logic [DATA_W-1:0]   divisor;
   logic                sgn;
   logic                sign1;
   logic                sign2;

   logic [DATA_W-1:0]   abs1;
   logic [DATA_W-1:0]   abs2;
   logic [DATA_W:0]     shifted;
   logic [DATA_W:0]     trial;
   logic                borrow;
   logic [DATA_W-1:0]   quo_fix;
   logic [DATA_W-1:0]   rem_fix;

   // Operand magnitudes, one restoring step, and final sign correction.
   always_comb begin
      abs1 = (signed_div_i && opdata1_i[DATA_W-1]) ? (DATA_W'(0) - opdata1_i) : opdata1_i;
      abs2 = (signed_div_i && opdata2_i[DATA_W-1]) ? (DATA_W'(0) - opdata2_i) : opdata2_i;
      shifted = {rem, quo[DATA_W-1]};
      trial   = shifted - {1'b0, divisor};
      // divisor < 2^DATA_W, so a wrapped subtraction always lands with the top bit set
      borrow  = trial[DATA_W];
      quo_fix = (sgn && (sign1 ^ sign2)) ? (DATA_W'(0) - quo) : quo;
      rem_fix = (sgn && sign1) ? (DATA_W'(0) - rem) : rem;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= FREE;
         counter  <= '0;
         rem      <= '0;
         quo      <= '0;
         divisor  <= '0;
         sgn      <= 1'b0;
         sign1    <= 1'b0;
         sign2    <= 1'b0;
         result_o <= '0;
         ready_o  <= 1'b0;
      end else begin
         case (state)
            FREE: begin
               ready_o  <= 1'b0;
               result_o <= '0;
               if (start_i && !annul_i) begin
                  if (opdata2_i == '0) begin
                     state <= BYZERO;
                  end else begin
                     state   <= ON;
                     quo     <= abs1;
                     divisor <= abs2;
                     rem     <= '0;
                     counter <= '0;
                     sgn     <= signed_div_i;
                     sign1   <= opdata1_i[DATA_W-1];
                     sign2   <= opdata2_i[DATA_W-1];
                  end
               end
            end
            BYZERO: begin
               state    <= END;
               result_o <= '0;
               ready_o  <= 1'b0;
            end
            ON: begin
               if (annul_i) begin
                  state    <= FREE;
                  ready_o  <= 1'b0;
                  result_o <= '0;
               end else if (counter == CNT_W'(DATA_W)) begin
                  state    <= END;
                  result_o <= {rem_fix, quo_fix};
                  ready_o  <= 1'b1;
               end else begin
                  rem     <= borrow ? shifted[DATA_W-1:0] : trial[DATA_W-1:0];
                  quo     <= {quo[DATA_W-2:0], ~borrow};
                  counter <= counter + CNT_W'(1);
               end
            end
            END: begin
               // A divide-by-zero arrives here with ready low; raise it one edge later.
               if (annul_i || (ready_o && !start_i)) begin
                  state    <= FREE;
                  ready_o  <= 1'b0;
                  result_o <= '0;
               end else begin
                  ready_o <= 1'b1;
               end
            end
            default: begin
               state    <= FREE;
               ready_o  <= 1'b0;
               result_o <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_div_seq.sv
// Bench for div_seq: directed vector table, multi-cycle corner sequences,
// and random divides checked against an arithmetic reference model.
module tb_div_seq;

   localparam int unsigned W = 32;

   logic            clk;
   logic            rst;
   logic            signed_div_i;
   logic [W-1:0]    opdata1_i;
   logic [W-1:0]    opdata2_i;
   logic            start_i;
   logic            annul_i;
   logic [2*W-1:0]  result_o;
   logic            ready_o;

   int errors = 0;
   int checks = 0;

   div_seq #(.DATA_W(W)) dut (
      .clk          (clk),
      .rst          (rst),
      .signed_div_i (signed_div_i),
      .opdata1_i    (opdata1_i),
      .opdata2_i    (opdata2_i),
      .start_i      (start_i),
      .annul_i      (annul_i),
      .result_o     (result_o),
      .ready_o      (ready_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic        sgn;
      logic [31:0] a;
      logic [31:0] b;
      logic [63:0] exp;
      int          lat;
   } vec_t;

   vec_t vecs[8];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Reference: truncating division on magnitudes, remainder follows the dividend.
   function automatic logic [63:0] model(input logic sgn, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] ua, ub, q, r;
      if (b == 32'd0) return 64'd0;
      ua = (sgn && a[31]) ? 32'd0 - a : a;
      ub = (sgn && b[31]) ? 32'd0 - b : b;
      q = ua / ub;
      r = ua % ub;
      if (sgn && (a[31] ^ b[31])) q = 32'd0 - q;
      if (sgn && a[31]) r = 32'd0 - r;
      return {r, q};
   endfunction

   task automatic scramble();
      signed_div_i = 1'($urandom);
      opdata1_i    = $urandom;
      opdata2_i    = $urandom;
   endtask

   // Present a request; returns just after the accept edge E0.
   task automatic accept(input logic sgn, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      signed_div_i = sgn;
      opdata1_i    = a;
      opdata2_i    = b;
      start_i      = 1'b1;
      annul_i      = 1'b0;
      @(posedge clk); #1;
      scramble();
   endtask

   // Count edges after E0 until ready, check result, hold, then release start.
   task automatic finish_div(input string name, input logic [63:0] exp, input int lat, input int hold);
      int n = 0;
      while (ready_o !== 1'b1 && n < 60) begin
         @(posedge clk); #1;
         n++;
      end
      chk({name, " latency"}, 64'(n), 64'(lat));
      chk({name, " result"}, result_o, exp);
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         chk({name, " held"}, {ready_o, result_o[62:0]}, {1'b1, exp[62:0]});
      end
      @(negedge clk);
      start_i = 1'b0;
      @(posedge clk); #1;
      chk({name, " release"}, {63'd0, ready_o} | result_o, 64'd0);
   endtask

   initial begin
      logic        s;
      logic [31:0] a, b;
      logic        seen;

      vecs[0] = '{"divu_100_7",     1'b0, 32'd100,       32'd7,         {32'h00000002, 32'h0000000E}, 33};
      vecs[1] = '{"div_m7_2",       1'b1, 32'hFFFFFFF9,  32'd2,         {32'hFFFFFFFF, 32'hFFFFFFFD}, 33};
      vecs[2] = '{"div_7_m2",       1'b1, 32'd7,         32'hFFFFFFFE,  {32'h00000001, 32'hFFFFFFFD}, 33};
      vecs[3] = '{"div_min_m1",     1'b1, 32'h80000000,  32'hFFFFFFFF,  {32'h00000000, 32'h80000000}, 33};
      vecs[4] = '{"divu_max_1",     1'b0, 32'hFFFFFFFF,  32'd1,         {32'h00000000, 32'hFFFFFFFF}, 33};
      vecs[5] = '{"div_by0",        1'b1, 32'h12345678,  32'd0,         64'd0,                        2};
      vecs[6] = '{"divu_by0",       1'b0, 32'hFFFFFFFF,  32'd0,         64'd0,                        2};
      vecs[7] = '{"divu_small_big", 1'b0, 32'd5,         32'hFFFFFFF0,  {32'h00000005, 32'h00000000}, 33};

      rst = 1'b1; start_i = 1'b0; annul_i = 1'b0;
      signed_div_i = 1'b0; opdata1_i = '0; opdata2_i = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset outputs", {63'd0, ready_o} | result_o, 64'd0);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 8; i++) begin
         accept(vecs[i].sgn, vecs[i].a, vecs[i].b);
         finish_div(vecs[i].name, vecs[i].exp, vecs[i].lat, 2);
      end

      // start and annul together in FREE: no accept
      @(negedge clk);
      start_i = 1'b1; annul_i = 1'b1; opdata1_i = 32'd8; opdata2_i = 32'd0;
      repeat (4) @(posedge clk);
      #1;
      chk("annul_blocks_start", {63'd0, ready_o}, 64'd0);
      @(negedge clk);
      start_i = 1'b0; annul_i = 1'b0;

      // annul sampled at E10 abandons the divide
      accept(1'b0, 32'd1000, 32'd3);
      repeat (9) @(posedge clk);
      @(negedge clk);
      annul_i = 1'b1; start_i = 1'b0;
      @(posedge clk); #1;
      chk("annul_e10", {63'd0, ready_o} | result_o, 64'd0);
      @(negedge clk);
      annul_i = 1'b0;
      seen = 1'b0;
      repeat (40) begin
         @(posedge clk); #1;
         if (ready_o === 1'b1) seen = 1'b1;
      end
      chk("annul_no_ready", {63'd0, seen}, 64'd0);
      accept(1'b0, 32'd9, 32'd3);
      finish_div("after_annul_9_3", {32'd0, 32'd3}, 33, 1);

      // async reset mid-ON, then a fresh accept with start still held
      accept(1'b1, 32'hFFFFFF9C, 32'd7);
      repeat (5) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("rst_mid_on", {63'd0, ready_o} | result_o, 64'd0);
      @(negedge clk);
      rst = 1'b0;
      signed_div_i = 1'b1; opdata1_i = 32'hFFFFFF9C; opdata2_i = 32'd7; start_i = 1'b1;
      @(posedge clk); #1;
      scramble();
      finish_div("after_rst_m100_7", model(1'b1, 32'hFFFFFF9C, 32'd7), 33, 1);

      // async reset while a result is being held must clear outputs between edges
      accept(1'b0, 32'd77, 32'd5);
      begin
         int n = 0;
         while (ready_o !== 1'b1 && n < 60) begin
            @(posedge clk); #1;
            n++;
         end
      end
      chk("end_ready_before_rst", {63'd0, ready_o}, 64'd1);
      #2;
      rst = 1'b1;
      #1;
      chk("rst_in_end", {63'd0, ready_o} | result_o, 64'd0);
      @(negedge clk);
      rst = 1'b0; start_i = 1'b0;

      // random divides against the reference model
      for (int i = 0; i < 40; i++) begin
         s = 1'($urandom);
         a = $urandom;
         case ($urandom_range(0, 7))
            0:       b = 32'd0;
            1:       b = 32'($urandom_range(1, 15));
            2:       b = 32'hFFFFFFFF;
            default: b = $urandom;
         endcase
         if ($urandom_range(0, 7) == 0) a = 32'h80000000;
         accept(s, a, b);
         finish_div($sformatf("rand%0d_%0d_%h_%h", i, s, a, b), model(s, a, b), (b == 32'd0) ? 2 : 33, 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
